// File: rtl/serial_alu.sv
// -----------------------------------------------------------------------------
// serial_alu
//
// Execution-side ALU that takes the 4-bit selection code from the ALU control
// decode and applies it to two XLEN operands.
// - Logic, arithmetic and compare operations finish in one cycle.
// - Shifts run iteratively, one bit position per cycle, so no barrel shifter
//   is needed.
// Valid/ready handshakes sit on both the request side and the result side.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operation request
//   in_ready   high only in IDLE; request accepted when in_valid & in_ready
//   alu_sel    operation code (ADD 0000, SUB 0001, PASS 0011, OR 0100,
//              AND 0101, XOR 0111, SRL 1000, SLL 1001, SRA 1010, SLT 1101,
//              SLTU 1111; any other code behaves as PASS)
//   op_a       operand A
//   op_b       operand B, also the shift amount source (low log2(XLEN) bits)
//   out_valid  result and flags are valid
//   out_ready  consumer accepts the result
//   result     operation result
//   zf         result == 0
//   cf         carry out of the adder (ADD/SUB only)
//   vf         signed overflow (ADD/SUB only)
//   sf         result sign bit
// -----------------------------------------------------------------------------
module serial_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zf,
    output logic            cf,
    output logic            vf,
    output logic            sf
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [XLEN-1:0] r_acc;
    logic [SHW-1:0]  r_cnt;
    logic [3:0]      r_shop;
    logic [XLEN-1:0] r_result;
    logic            r_zf;
    logic            r_cf;
    logic            r_vf;
    logic            r_sf;

    logic            w_accept;
    logic            w_is_shift;
    logic [SHW-1:0]  w_shamt;
    logic            w_is_sub;
    logic [XLEN-1:0] w_b_eff;
    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_comb_res;
    logic            w_comb_cf;
    logic            w_comb_vf;
    logic [XLEN-1:0] w_acc_step;
    logic            w_shift_last;

    assign w_accept     = in_valid && (r_state == S_IDLE);
    assign w_is_shift   = (alu_sel == OP_SRL) || (alu_sel == OP_SLL) || (alu_sel == OP_SRA);
    assign w_shamt      = op_b[SHW-1:0];
    assign w_shift_last = (r_cnt == SHW'(1));

    // SUB reuses the adder as A + ~B + 1, so its carry out means A >= B unsigned.
    assign w_is_sub = (alu_sel == OP_SUB);
    assign w_b_eff  = w_is_sub ? ~op_b : op_b;
    assign w_sum    = {1'b0, op_a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_is_sub};

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_comb_res = op_b;
        w_comb_cf  = 1'b0;
        w_comb_vf  = 1'b0;
        case (alu_sel)
            OP_ADD, OP_SUB: begin
                w_comb_res = w_sum[XLEN-1:0];
                w_comb_cf  = w_sum[XLEN];
                // Overflow when the effective operands share a sign that the
                // sum does not; w_b_eff already carries the inversion for SUB.
                w_comb_vf  = (op_a[XLEN-1] == w_b_eff[XLEN-1]) &&
                             (w_sum[XLEN-1] != op_a[XLEN-1]);
            end
            OP_OR:   w_comb_res = op_a | op_b;
            OP_AND:  w_comb_res = op_a & op_b;
            OP_XOR:  w_comb_res = op_a ^ op_b;
            OP_SLT:  w_comb_res = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: w_comb_res = XLEN'(op_a < op_b);
            default: w_comb_res = op_b;
        endcase
    end

    // One bit position per cycle on the latched shift opcode.
    always_comb begin
        w_acc_step = r_acc;
        case (r_shop)
            OP_SRL:  w_acc_step = {1'b0, r_acc[XLEN-1:1]};
            OP_SLL:  w_acc_step = {r_acc[XLEN-2:0], 1'b0};
            OP_SRA:  w_acc_step = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_acc_step = r_acc;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_is_shift && (w_shamt != '0)) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_shift_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_shop   <= '0;
            r_result <= '0;
            r_zf     <= 1'b0;
            r_cf     <= 1'b0;
            r_vf     <= 1'b0;
            r_sf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift) begin
                            r_acc  <= op_a;
                            r_cnt  <= w_shamt;
                            r_shop <= alu_sel;
                            // A zero shift amount completes immediately.
                            if (w_shamt == '0) begin
                                r_result <= op_a;
                                r_zf     <= (op_a == '0);
                                r_sf     <= op_a[XLEN-1];
                                r_cf     <= 1'b0;
                                r_vf     <= 1'b0;
                            end
                        end else begin
                            r_result <= w_comb_res;
                            r_zf     <= (w_comb_res == '0);
                            r_sf     <= w_comb_res[XLEN-1];
                            r_cf     <= w_comb_cf;
                            r_vf     <= w_comb_vf;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt - SHW'(1);
                    if (w_shift_last) begin
                        r_result <= w_acc_step;
                        r_zf     <= (w_acc_step == '0);
                        r_sf     <= w_acc_step[XLEN-1];
                        r_cf     <= 1'b0;
                        r_vf     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zf        = r_zf;
    assign cf        = r_cf;
    assign vf        = r_vf;
    assign sf        = r_sf;

endmodule

// File: tb/tb_serial_alu.sv
// -----------------------------------------------------------------------------
// tb_serial_alu
//
// Self-checking bench for serial_alu (XLEN = 32). Each issued operation pushes
// its expected result, flags and latency onto a scoreboard queue; the entry is
// popped and compared when out_valid appears. Also covers reset state,
// result backpressure and reset in the middle of a shift.
// -----------------------------------------------------------------------------
module tb_serial_alu;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        logic        cf;
        logic        vf;
        logic        sf;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zf;
    logic        cf;
    logic        vf;
    logic        sf;

    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    serial_alu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zf        (zf),
        .cf        (cf),
        .vf        (vf),
        .sf        (sf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model written from the operation definitions.
    function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        logic [4:0]  sh;
        sh    = b[4:0];
        e.cf  = 1'b0;
        e.vf  = 1'b0;
        e.lat = 1;
        case (sel)
            4'b0000: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[31:0];
                e.cf  = s[32];
                e.vf  = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b0001: begin
                s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.res = s[31:0];
                e.cf  = s[32];
                e.vf  = (a[31] != b[31]) && (s[31] != a[31]);
            end
            4'b0100: e.res = a | b;
            4'b0101: e.res = a & b;
            4'b0111: e.res = a ^ b;
            4'b1000: begin e.res = a >> sh;                     e.lat = int'(sh) + 1; end
            4'b1001: begin e.res = a << sh;                     e.lat = int'(sh) + 1; end
            4'b1010: begin e.res = 32'($signed(a) >>> sh);      e.lat = int'(sh) + 1; end
            4'b1101: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1111: e.res = (a < b) ? 32'd1 : 32'd0;
            default: e.res = b;
        endcase
        e.zf = (e.res == 32'd0);
        e.sf = e.res[31];
        return e;
    endfunction

    // Issue one op, wait for its result, compare against the scoreboard,
    // hold out_ready low for 'hold' cycles, then retire it.
    task automatic run_op(input string name, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        exp_t e;
        int   lat;
        bit   busy_ok;
        @(negedge clk);
        check({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        alu_sel  = sel;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(sel, a, b));
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Scramble inputs after the accept edge; they must be ignored.
                in_valid = 1'b1;
                alu_sel  = 4'($urandom);
                op_a     = $urandom;
                op_b     = $urandom;
            end
            if (in_ready) busy_ok = 1'b0;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        if (!out_valid) begin
            check({name, ".timeout"}, 32'(out_valid), 32'd1);
            void'(sb_q.pop_front());
            return;
        end
        if (sb_q.size() == 0) begin
            check({name, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({name, ".latency"}, 32'(lat), 32'(e.lat));
        check({name, ".in_ready_busy"}, 32'(busy_ok), 32'd1);
        check({name, ".result"}, result, e.res);
        check({name, ".flags_zcvs"}, {28'd0, zf, cf, vf, sf}, {28'd0, e.zf, e.cf, e.vf, e.sf});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, ".hold_result"}, result, e.res);
            check({name, ".hold_ctl"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, ".retire_ctl"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_sel   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.ctl", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        check("reset.result", result, 32'd0);
        check("reset.flags", {28'd0, zf, cf, vf, sf}, 32'd0);

        run_op("add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("sub_eq",   4'b0001, 32'd5,         32'd5,         0);
        run_op("sub_brw",  4'b0001, 32'd0,         32'd1,         0);
        run_op("add_cry",  4'b0000, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        run_op("sub_vf",   4'b0001, 32'h8000_0000, 32'h0000_0001, 0);
        run_op("sra4",     4'b1010, 32'h8000_0000, 32'd4,         0);
        run_op("sll33",    4'b1001, 32'h0000_0001, 32'h0000_0021, 0);
        run_op("sll0",     4'b1001, 32'hDEAD_BEEF, 32'd0,         0);
        run_op("srl7",     4'b1000, 32'hF000_0001, 32'd7,         0);
        run_op("sra_pos",  4'b1010, 32'h4000_0000, 32'd31,        0);
        run_op("sltu",     4'b1111, 32'd1,         32'hFFFF_FFFF, 0);
        run_op("slt",      4'b1101, 32'd1,         32'hFFFF_FFFF, 0);
        run_op("slt_neg",  4'b1101, 32'hFFFF_FFFF, 32'd1,         0);
        run_op("unknown",  4'b0110, 32'h5555_5555, 32'h0000_1234, 0);
        run_op("pass",     4'b0011, 32'h1,         32'h0,         0);
        run_op("or",       4'b0100, 32'hF0F0_0000, 32'h0000_0F0F, 0);
        run_op("and",      4'b0101, 32'hFF00_FF00, 32'h0F0F_0F0F, 0);
        run_op("xor_bp",   4'b0111, 32'hAAAA_AAAA, 32'h5555_5555, 3);

        for (int k = 0; k < 12; k++) begin
            logic [3:0] sel_tab [11];
            sel_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0111,
                        4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1111};
            run_op("rand", sel_tab[$urandom_range(10, 0)], $urandom, $urandom, 0);
        end

        // Reset in the middle of an SRL by 20.
        @(negedge clk);
        alu_sel  = 4'b1000;
        op_a     = 32'hFFFF_FFFF;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midshift.busy", {30'd0, in_ready, out_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midshift.ctl", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        check("midshift.result", result, 32'd0);
        check("midshift.flags", {28'd0, zf, cf, vf, sf}, 32'd0);
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            check("midshift.no_out", {31'd0, out_valid}, 32'd0);
        end

        run_op("post_rst", 4'b0000, 32'd3, 32'd4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Execution-side consumer of the 4-bit ALU selection code produced by the ALU control decode; performs the selected operation on two XLEN operands.
- Logic/arithmetic/compare ops complete in one cycle.
- Shifts run iteratively, 1 bit per cycle, trading barrel-shifter area for latency.
- Valid/ready handshakes on input and output; sits between decode/operand-select and writeback/branch-resolve in the multi-cycle datapath.

Parameters:
- XLEN, 32, operand/result width; shift amount = B[$clog2(XLEN)-1:0].

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  high only in IDLE; request accepted on edge where in_valid & in_ready
- alu_sel  in  4  operation code (encoding below)
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B / shift amount source
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zf  out  1  result == 0
- cf  out  1  carry out (ADD/SUB only)
- vf  out  1  signed overflow (ADD/SUB only)
- sf  out  1  result[XLEN-1]

Behaviour:
- Encoding (fixed): ADD 0000, SUB 0001, PASS 0011, OR 0100, AND 0101, XOR 0111, SRL 1000, SLL 1001, SRA 1010, SLT 1101, SLTU 1111.
- Any other code behaves as PASS.
- States: IDLE, SHIFT, DONE.
- Reset (rst high at edge): state=IDLE, result=0, zf=cf=vf=sf=0, out_valid=0, in_ready=1, shift counter=0. Reset wins over every other event, including mid-SHIFT and DONE-awaiting-out_ready; the in-flight op is discarded.
- IDLE, accept on a non-shift op:
  - Compute and register result and flags; go to DONE.
  - out_valid is high in the cycle after the accept edge (latency 1).
- IDLE, accept on a shift op (SRL/SLL/SRA):
  - Load accumulator=op_a, count=shamt, latch opcode.
  - count==0: go directly to DONE with result=op_a (latency 1).
  - Otherwise go to SHIFT.
- SHIFT, each cycle: shift accumulator 1 bit (SRL zero-fill, SLL zero-fill, SRA sign-fill); count decrements. When count reaches 0, go to DONE with result=accumulator. Total latency = shamt+1 cycles from accept edge to out_valid.
- Operands and alu_sel are sampled only on the accept edge; later input changes have no effect.
- DONE:
  - out_valid=1; result/flags held stable.
  - On an edge with out_ready=1, go to IDLE; out_valid drops, in_ready rises the next cycle.
  - No same-cycle re-accept; minimum issue interval is 2 cycles.
- Arithmetic:
  - ADD/SUB are modulo 2^XLEN.
  - SUB is computed as A + ~B + 1.
  - cf = carry out of the XLEN-bit adder; for SUB, cf=1 means A >= B unsigned.
  - ADD vf = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - SUB vf = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
  - Non-ADD/SUB ops: cf=vf=0.
  - zf and sf are always derived from the final result.
- SLT: result = 1 if signed A < B, else 0. SLTU: unsigned compare.
- PASS: result = op_b.
- Only B[log2 XLEN - 1:0] is used for shifts; upper bits of B are ignored (B=33 means shift by 1).
- in_valid during SHIFT/DONE is ignored; in_ready=0 there.

Test Plan:
- ADD A=0x7FFFFFFF, B=1 -> out_valid 1 cycle after accept, result 0x80000000, vf=1, sf=1, cf=0, zf=0.
- SUB A=5, B=5 -> result 0, zf=1, cf=1, vf=0. SUB A=0, B=1 -> result 0xFFFFFFFF, cf=0, sf=1.
- SRA A=0x80000000, B=4 -> out_valid exactly 5 cycles after accept, result 0xF8000000, in_ready low throughout.
- SLL A=0x1, B=0x21 -> shift by 1, result 0x2, latency 2. SLL with B=0 -> result=A, latency 1.
- SLTU A=1, B=0xFFFFFFFF -> result 1. SLT same operands -> result 0. Unknown code 0110 with B=0x1234 -> result 0x1234.
- Backpressure and reset:
  - out_ready held low 3 cycles -> result/out_valid stable, in_ready=0.
  - rst asserted mid-SHIFT (SRL by 20, after 5 cycles) -> next cycle IDLE, in_ready=1, out_valid=0, result=0.
